// File: rtl/fighter_pkg.sv
// Shared definitions for the per-player fighter controller: state codes,
// frame counter width and a helper that sizes a frame duration in bits.
package fighter_pkg;

    localparam int FRAME_W = 5;

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_LEFT        = 3'd1;
    localparam logic [2:0] S_RIGHT       = 3'd2;
    localparam logic [2:0] S_ATK_START   = 3'd3;
    localparam logic [2:0] S_ATK_ACTIVE  = 3'd4;
    localparam logic [2:0] S_ATK_RECOVER = 3'd5;
    localparam logic [2:0] S_STUN        = 3'd6;

    // Number of bits needed to hold a frame duration; used to reject
    // durations that would not fit the frame counter.
    function automatic int frame_bits(input int dur);
        int bits;
        bits = 0;
        for (int i = 0; i < 31; i++) begin
            if ((dur >> i) != 0) bits = i + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame countdown used by the timed fighter states: load on entry,
// decrement once per enabled cycle, done while the count reads 1.
module frame_timer
    import fighter_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               load,
    input  logic [FRAME_W-1:0] load_val,
    output logic [FRAME_W-1:0] cnt,
    output logic               done
);

    logic [FRAME_W-1:0] cnt_q;

    // Load wins over decrement; the count parks at zero in untimed states.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (en) begin
            if (load) begin
                cnt_q <= load_val;
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign cnt  = cnt_q;
    assign done = (cnt_q == FRAME_W'(1));

endmodule

// File: rtl/fighter_fsm.sv
// Per-player action controller: free movement, neutral/directional attack
// sequence, hit-stun and a saturating position, advancing on frame_tick.
module fighter_fsm
    import fighter_pkg::*;
#(
    parameter int POS_W        = 8,
    parameter int POS_MIN      = 0,
    parameter int POS_MAX      = 200,
    parameter int POS_INIT     = 20,
    parameter int STEP         = 2,
    parameter int STARTUP      = 5,
    parameter int ACTIVE       = 2,
    parameter int RECOVERY     = 16,
    parameter int DIR_STARTUP  = 4,
    parameter int DIR_ACTIVE   = 3,
    parameter int DIR_RECOVERY = 15,
    parameter int STUN         = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               left,
    input  logic               right,
    input  logic               attack,
    input  logic               hit_in,
    output logic [2:0]         state,
    output logic [POS_W-1:0]   pos,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               move_flag,
    output logic               attack_flag,
    output logic               directional_attack_flag,
    output logic               hitbox_active,
    output logic               stun_flag
);

    if (frame_bits(STARTUP) > FRAME_W || frame_bits(ACTIVE) > FRAME_W ||
        frame_bits(RECOVERY) > FRAME_W || frame_bits(DIR_STARTUP) > FRAME_W ||
        frame_bits(DIR_ACTIVE) > FRAME_W || frame_bits(DIR_RECOVERY) > FRAME_W ||
        frame_bits(STUN) > FRAME_W || STARTUP < 1 || ACTIVE < 1 || RECOVERY < 1 ||
        DIR_STARTUP < 1 || DIR_ACTIVE < 1 || DIR_RECOVERY < 1 || STUN < 1) begin : g_bad_duration
        $error("fighter_fsm: every frame duration must be in 1..31");
    end

    localparam logic [FRAME_W-1:0] STARTUP_C      = FRAME_W'(STARTUP);
    localparam logic [FRAME_W-1:0] ACTIVE_C       = FRAME_W'(ACTIVE);
    localparam logic [FRAME_W-1:0] RECOVERY_C     = FRAME_W'(RECOVERY);
    localparam logic [FRAME_W-1:0] DIR_STARTUP_C  = FRAME_W'(DIR_STARTUP);
    localparam logic [FRAME_W-1:0] DIR_ACTIVE_C   = FRAME_W'(DIR_ACTIVE);
    localparam logic [FRAME_W-1:0] DIR_RECOVERY_C = FRAME_W'(DIR_RECOVERY);
    localparam logic [FRAME_W-1:0] STUN_C         = FRAME_W'(STUN);

    localparam logic [POS_W:0]   POS_MIN_X  = (POS_W+1)'(POS_MIN);
    localparam logic [POS_W:0]   POS_MAX_X  = (POS_W+1)'(POS_MAX);
    localparam logic [POS_W:0]   STEP_X     = (POS_W+1)'(STEP);
    localparam logic [POS_W-1:0] POS_INIT_C = POS_W'(POS_INIT);

    logic [2:0]         state_q, state_d;
    logic               dir_q, dir_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [POS_W:0]     pos_ext, pos_sum, pos_diff;
    logic               timer_load, timer_done;
    logic [FRAME_W-1:0] timer_val, timer_cnt;

    // frame_tick is a one-cycle enable strobe with no backpressure: every
    // register below samples its inputs only on cycles where it is high.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        case (state_q)
            S_IDLE, S_LEFT, S_RIGHT: begin
                if (hit_in) begin
                    state_d = S_STUN;
                end else if (attack) begin
                    state_d = S_ATK_START;
                    dir_d   = (state_q != S_IDLE);
                end else if (left && right) begin
                    state_d = S_IDLE;
                end else if (left) begin
                    state_d = S_LEFT;
                end else if (right) begin
                    state_d = S_RIGHT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ATK_START: begin
                if (hit_in)          state_d = S_STUN;
                else if (timer_done) state_d = S_ATK_ACTIVE;
            end
            // Hits during the active window trade and are dropped.
            S_ATK_ACTIVE: begin
                if (timer_done) state_d = S_ATK_RECOVER;
            end
            S_ATK_RECOVER: begin
                if (hit_in)          state_d = S_STUN;
                else if (timer_done) state_d = S_IDLE;
            end
            S_STUN: begin
                if (hit_in)          state_d = S_STUN;
                else if (timer_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d != S_ATK_START && state_d != S_ATK_ACTIVE && state_d != S_ATK_RECOVER) begin
            dir_d = 1'b0;
        end
    end

    // Any state change reloads the timer (zero for free states); a hit
    // while stunned restarts the stun count.
    always_comb begin
        timer_load = (state_d != state_q) || (state_q == S_STUN && hit_in);
        case (state_d)
            S_ATK_START:   timer_val = dir_d ? DIR_STARTUP_C  : STARTUP_C;
            S_ATK_ACTIVE:  timer_val = dir_d ? DIR_ACTIVE_C   : ACTIVE_C;
            S_ATK_RECOVER: timer_val = dir_d ? DIR_RECOVERY_C : RECOVERY_C;
            S_STUN:        timer_val = STUN_C;
            default:       timer_val = '0;
        endcase
    end

    always_comb begin
        pos_ext  = {1'b0, pos_q};
        pos_sum  = pos_ext + STEP_X;
        pos_diff = pos_ext - STEP_X;
        pos_d    = pos_q;
        if (state_q == S_LEFT) begin
            pos_d = (pos_ext < POS_MIN_X + STEP_X) ? POS_MIN_X[POS_W-1:0] : pos_diff[POS_W-1:0];
        end else if (state_q == S_RIGHT) begin
            pos_d = (pos_sum > POS_MAX_X) ? POS_MAX_X[POS_W-1:0] : pos_sum[POS_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            dir_q   <= 1'b0;
        end else if (frame_tick) begin
            state_q <= state_d;
            dir_q   <= dir_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pos_q <= POS_INIT_C;
        end else if (frame_tick) begin
            pos_q <= pos_d;
        end
    end

    frame_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .en       (frame_tick),
        .load     (timer_load),
        .load_val (timer_val),
        .cnt      (timer_cnt),
        .done     (timer_done)
    );

    assign state                   = state_q;
    assign pos                     = pos_q;
    assign frame_cnt               = timer_cnt;
    assign move_flag               = (state_q == S_LEFT) || (state_q == S_RIGHT);
    assign attack_flag             = (state_q == S_ATK_START) || (state_q == S_ATK_ACTIVE) ||
                                     (state_q == S_ATK_RECOVER);
    assign directional_attack_flag = dir_q & attack_flag;
    assign hitbox_active           = (state_q == S_ATK_ACTIVE);
    assign stun_flag               = (state_q == S_STUN);

endmodule

// File: doc/fighter_fsm.md
# fighter_fsm

Parametrised per-player action controller for the two-player fighting game: turns debounced left/right/attack buttons and an external hit strobe into a frame-based state machine with a configurable attack sequence (startup → active → recovery), a directional attack variant, hit-stun, and a saturating horizontal position counter. It sits between the button-conditioning logic and the renderer/collision block, and advances only on the game frame tick.

## Interface
Parameters:
- POS_W, 8, position width in pixels
- POS_MIN, 0, leftmost legal position
- POS_MAX, 200, rightmost legal position
- POS_INIT, 20, position after reset
- STEP, 2, pixels moved per frame tick
- STARTUP, 5, neutral attack startup frames (≥1)
- ACTIVE, 2, neutral attack active frames (≥1)
- RECOVERY, 16, neutral attack recovery frames (≥1)
- DIR_STARTUP, 4, directional attack startup frames (≥1)
- DIR_ACTIVE, 3, directional attack active frames (≥1)
- DIR_RECOVERY, 15, directional attack recovery frames (≥1)
- STUN, 10, hit-stun frames (≥1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (reset = 0 clears on the next clk edge)
- frame_tick  in  1  one-cycle strobe; all state and position updates happen only on cycles where it is 1
- left  in  1  left button, level
- right  in  1  right button, level
- attack  in  1  attack button, level
- hit_in  in  1  opponent hit landed, sampled only on frame_tick
- state  out  3  current state code
- pos  out  POS_W  horizontal position
- frame_cnt  out  5  frames remaining in the current timed state, 0 otherwise
- move_flag  out  1  state is LEFT or RIGHT
- attack_flag  out  1  state is ATK_START, ATK_ACTIVE or ATK_RECOVER
- directional_attack_flag  out  1  the current attack is the directional variant
- hitbox_active  out  1  state is ATK_ACTIVE
- stun_flag  out  1  state is STUN

## Operation
- States: IDLE=0, LEFT=1, RIGHT=2, ATK_START=3, ATK_ACTIVE=4, ATK_RECOVER=5, STUN=6. Code 7 is illegal and returns to IDLE on the next tick.
- Free states (IDLE/LEFT/RIGHT), per tick, priority: hit_in → STUN; attack → ATK_START; left&right both high → IDLE; left → LEFT; right → RIGHT; else IDLE.
- Directional attack: attack taken from LEFT or RIGHT sets the dir register to 1 and loads DIR_STARTUP. Attack taken from IDLE clears dir and loads STARTUP. dir holds until the attack ends.
- Timed states load frame_cnt = duration on entry. They decrement once per tick and exit on the tick where frame_cnt = 1.
  - Exit order: ATK_START → ATK_ACTIVE → ATK_RECOVER → IDLE. ACTIVE/RECOVERY lengths are chosen by dir.
- Buttons are ignored in timed states; no buffering.
- hit_in on a tick in any state except ATK_ACTIVE goes to STUN, loads STUN, and clears dir. This includes a hit during STUN, which reloads the counter. A hit in ATK_ACTIVE is ignored (trade rule).
- STUN exits to IDLE.
- Position: on a tick while in LEFT, pos = max(pos − STEP, POS_MIN); in RIGHT, pos = min(pos + STEP, POS_MAX). Compute in POS_W+1 bits so there is no wrap. The update uses the state held before the tick (Moore).
- All flags and state are decoded from the registered state, with no input-to-output combinational path. directional_attack_flag = dir & attack_flag.
- frame_cnt is 5 bits. Every duration parameter must be ≤ 31; elaborate-time check.

## Timing
- Reset (reset = 0 at a clk edge) gives: state=IDLE, pos=POS_INIT, frame_cnt=0, dir=0, all flags 0. Reset mid-attack or mid-stun aborts immediately.
- Reset has priority over frame_tick.
- Inputs are sampled only at clk edges where frame_tick = 1. Outputs change one clk after that edge and hold until the next tick.
- Neutral attack total: STARTUP + ACTIVE + RECOVERY ticks from the entry tick to IDLE. hitbox_active is high for exactly ACTIVE ticks.
- Holding attack continuously re-attacks on the first tick after returning to IDLE.

## Structure
- Shared package `fighter_pkg`: state codes and a function for the max frame-count width.
- One sub-module, `frame_timer`: load/decrement/done counter, enabled by frame_tick.
- Everything else is flat: a next-state block, a state/dir register, and a position register.

## Test plan
- Reset, then hold right for 120 ticks → pos rises 20, 22, … and saturates at 200; move_flag=1, state=2.
- Attack from IDLE with default params → ATK_START for 5 ticks, ATK_ACTIVE for 2 (hitbox_active=1), ATK_RECOVER for 16, then IDLE; directional_attack_flag=0 throughout.
- Hold left 3 ticks, then attack → directional attack with 4/3/15 frames; directional_attack_flag=1 for 22 ticks; pos frozen during the attack.
- hit_in during ATK_START → STUN, frame_cnt=10, dir cleared. hit_in during ATK_ACTIVE → ignored. Second hit at stun frame_cnt=3 → reload to 10.
- left&right both high from IDLE → stays IDLE and pos unchanged. frame_tick=0 with buttons toggling → no state change.
- reset=0 during ATK_RECOVER with pos=150 → next clk: state=0, pos=20, frame_cnt=0, all flags 0.
